// File: rtl/reg_dump_pkg.sv
// Shared types and defaults for the register-file debug dump reader.
package reg_dump_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        SEND,
        DONE
    } dump_state_t;

endpackage

// File: rtl/reg_idx_counter.sv
// Wrapping register index counter with load/increment and an end-of-range flag.
// Loads first/last on i_load, steps by one on i_inc; o_is_last is combinational.
module reg_idx_counter
    import reg_dump_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_first,
    input  logic [ADDR_W-1:0] i_last,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_idx,
    output logic              o_is_last
);

    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx  <= '0;
            r_last <= '0;
        end else if (i_load) begin
            r_idx  <= i_first;
            r_last <= i_last;
        end else if (i_inc) begin
            // Natural overflow gives the 31 -> 0 wrap for first > last ranges.
            r_idx <= r_idx + ADDR_W'(1);
        end
    end

    assign o_idx     = r_idx;
    assign o_is_last = (r_idx == r_last);

endmodule

// File: rtl/reg_dump_reader.sv
// Walks a register-file range through a spare read port and streams {idx, data} beats.
// First beat valid two edges after start; stalls on CPU write collisions and on out_ready=0.
module reg_dump_reader
    import reg_dump_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    dump_state_t       r_state;
    dump_state_t       w_state_nxt;

    logic              w_load;
    logic              w_inc;
    logic              w_capture;
    logic              w_collision;
    logic              w_handshake;
    logic              w_is_last;
    logic [ADDR_W-1:0] w_idx;

    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_idx;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_last;
    logic              r_busy;
    logic              r_done;

    reg_idx_counter #(
        .ADDR_W (ADDR_W)
    ) u_idx_counter (
        .i_clk     (Clk),
        .i_rst_n   (reset),
        .i_load    (w_load),
        .i_first   (first_reg),
        .i_last    (last_reg),
        .i_inc     (w_inc),
        .o_idx     (w_idx),
        .o_is_last (w_is_last)
    );

    // A CPU write to the index being read (r0 is hardwired, so exempt) delays
    // the capture until the write has landed, keeping the dumped value coherent.
    assign w_collision = wr_en && (wr_addr == w_idx) && (wr_addr != '0);
    assign w_handshake = r_out_valid && out_ready;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_inc       = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (!w_collision) begin
                    w_capture   = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (w_handshake) begin
                    if (r_out_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_inc       = 1'b1;
                        w_state_nxt = ADDR;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_busy <= 1'b1;
            end
            if (r_state == DONE) begin
                r_busy <= 1'b0;
            end
            if (w_capture) begin
                r_out_valid <= 1'b1;
                r_out_idx   <= w_idx;
                r_out_data  <= rf_data;
                r_out_last  <= w_is_last;
            end
            // out_idx/out_data are left holding the final beat after the dump.
            if ((r_state == SEND) && w_handshake) begin
                r_out_valid <= 1'b0;
                if (r_out_last) begin
                    r_out_last <= 1'b0;
                    r_done     <= 1'b1;
                end
            end
        end
    end

    assign rf_addr   = w_idx;
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: register-file model plus an expected-beat queue.
module tb_reg_dump_reader;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          Clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] first_reg;
    logic [AW-1:0] last_reg;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_idx;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] rf [32];
    assign rf_data = rf[rf_addr];

    reg_dump_reader #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .Clk       (Clk),
        .reset     (reset),
        .start     (start),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    beat_t got_b;
    beat_t exp_b;

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int e0         = 0;
    int done_cyc   = 0;
    int done_cnt   = 0;
    int beats_seen = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Scoreboard: a beat is consumed at the next posedge when valid&ready at negedge.
    always @(negedge Clk) begin
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            got_b = '{out_idx, out_data, out_last};
            beats_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $error("FAIL beat_unexpected got idx=%0d data=%0h last=%0b exp none", out_idx, out_data, out_last);
            end else begin
                exp_b = exp_q.pop_front();
                assert (got_b === exp_b) else begin
                    failures++;
                    $error("FAIL beat got idx=%0d data=%0h last=%0b exp idx=%0d data=%0h last=%0b",
                           got_b.idx, got_b.data, got_b.last, exp_b.idx, exp_b.data, exp_b.last);
                end
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic push_range(input logic [AW-1:0] f, input logic [AW-1:0] l);
        logic [AW-1:0] idx;
        int n;
        idx = f;
        n   = int'(AW'(l - f)) + 1;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{idx, rf[idx], (k == n - 1)});
            idx = idx + AW'(1);
        end
    endtask

    task automatic do_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
        start     = 1'b1;
        first_reg = f;
        last_reg  = l;
        tick(1);
        start     = 1'b0;
        first_reg = AW'($urandom);
        last_reg  = AW'($urandom);
        e0        = cyc;
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (done === 1'b1) begin
                ok       = 1'b1;
                done_cyc = cyc;
                break;
            end
        end
        checks++;
        assert (ok) else begin
            failures++;
            $error("FAIL %s_timeout got=no_done exp=done_within_%0d", tag, budget);
        end
    endtask

    // Returns at posedge+1 once the reader is in its capture cycle for idx.
    task automatic wait_addr(input logic [AW-1:0] idx, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (rf_addr === idx && out_valid === 1'b0 && busy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        assert (ok) else begin
            failures++;
            $error("FAIL %s_timeout got=never exp=rf_addr_%0d", tag, idx);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({rf_addr, out_valid, out_idx, out_data, out_last, busy, done});
    endfunction

    initial begin
        int b0;
        int d0;
        bit ok;

        for (int i = 0; i < 32; i++) rf[i] = DW'(i * 4);
        reset = 1'b0; start = 1'b0; first_reg = '0; last_reg = '0;
        wr_en = 1'b0; wr_addr = '0; out_ready = 1'b1;

        // Reset with random inputs.
        repeat (4) begin
            tick(1);
            start     = 1'($urandom);
            first_reg = AW'($urandom);
            last_reg  = AW'($urandom);
            wr_en     = 1'($urandom);
            wr_addr   = AW'($urandom);
            out_ready = 1'($urandom);
        end
        #1;
        chk("reset_outputs", all_outs(), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        start = 1'b0; wr_en = 1'b0; out_ready = 1'b1;
        tick(1);
        reset = 1'b1;
        tick(3);
        chk("post_reset_idle", all_outs(), 64'd0);

        // Full 32-register dump.
        b0 = beats_seen; d0 = done_cnt;
        push_range(5'd0, 5'd31);
        do_start(5'd0, 5'd31);
        chk("full_busy_after_e0", 64'(busy), 64'd1);
        chk("full_rf_addr_after_e0", 64'(rf_addr), 64'd0);
        tick(1);
        chk("full_first_valid_after_e1", 64'({out_valid, out_idx, out_data}), 64'({1'b1, 5'd0, 32'd0}));
        wait_done(200, "full");
        chk("full_done_cycle", 64'(done_cyc - e0), 64'd64);
        chk("full_busy_with_done", 64'(busy), 64'd1);
        @(negedge Clk);
        #1;
        chk("full_done_dropped", 64'(done), 64'd0);
        chk("full_busy_dropped", 64'(busy), 64'd0);
        chk("full_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("full_beat_count", 64'(beats_seen - b0), 64'd32);
        chk("full_queue_empty", 64'(exp_q.size()), 64'd0);

        // Wrapping range 30 -> 1.
        tick(2);
        b0 = beats_seen;
        push_range(5'd30, 5'd1);
        do_start(5'd30, 5'd1);
        wait_done(100, "wrap");
        chk("wrap_beat_count", 64'(beats_seen - b0), 64'd4);
        chk("wrap_queue_empty", 64'(exp_q.size()), 64'd0);

        // Back-pressure on beat idx 2.
        tick(2);
        b0 = beats_seen;
        push_range(5'd0, 5'd4);
        do_start(5'd0, 5'd4);
        wait_addr(5'd2, "bp");
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("bp_hold", 64'({out_valid, out_idx, out_data}), 64'({1'b1, 5'd2, 32'd8}));
        end
        out_ready = 1'b1;
        wait_done(100, "bp");
        chk("bp_beat_count", 64'(beats_seen - b0), 64'd5);
        chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Collision on r5: CPU write 0x14 -> 0xDEAD while the reader sits on idx 5.
        tick(2);
        exp_q.push_back('{5'd4, 32'h10, 1'b0});
        exp_q.push_back('{5'd5, 32'hDEAD, 1'b0});
        exp_q.push_back('{5'd6, 32'h18, 1'b1});
        do_start(5'd4, 5'd6);
        wait_addr(5'd5, "coll");
        wr_en = 1'b1; wr_addr = 5'd5;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                @(negedge Clk);
                rf[5] = 32'hDEAD;
            end
            tick(1);
            chk("coll_stalled", 64'(out_valid), 64'd0);
        end
        wr_en = 1'b0;
        tick(1);
        chk("coll_capture", 64'({out_valid, out_idx, out_data}), 64'({1'b1, 5'd5, 32'hDEAD}));
        wait_done(100, "coll");
        chk("coll_queue_empty", 64'(exp_q.size()), 64'd0);

        // A write to r0 never stalls.
        tick(2);
        wr_en = 1'b1; wr_addr = 5'd0;
        push_range(5'd0, 5'd1);
        do_start(5'd0, 5'd1);
        wait_done(50, "wr0");
        chk("wr0_no_stall_cycles", 64'(done_cyc - e0), 64'd4);
        tick(1);
        wr_en = 1'b0;

        // Reset in the middle of a dump.
        tick(2);
        push_range(5'd0, 5'd31);
        do_start(5'd0, 5'd31);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (out_valid === 1'b1 && out_idx === 5'd10) begin
                ok = 1'b1;
                break;
            end
        end
        chk("midreset_reached_idx10", 64'(ok), 64'd1);
        reset = 1'b0;
        #1;
        chk("midreset_outputs_cleared", all_outs(), 64'd0);
        exp_q.delete();
        d0 = done_cnt;
        tick(3);
        reset = 1'b1;
        tick(3);
        chk("midreset_no_done", 64'(done_cnt - d0), 64'd0);
        chk("midreset_idle_after_release", all_outs(), 64'd0);

        // Restart from 0; a start while busy must be dropped.
        b0 = beats_seen;
        push_range(5'd0, 5'd3);
        do_start(5'd0, 5'd3);
        chk("restart_rf_addr", 64'(rf_addr), 64'd0);
        tick(2);
        start = 1'b1; first_reg = 5'd20; last_reg = 5'd25;
        tick(1);
        start = 1'b0;
        wait_done(100, "restart");
        tick(4);
        chk("restart_beat_count", 64'(beats_seen - b0), 64'd4);
        chk("restart_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("restart_idle_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
